// File: rtl/tube_scan_shifter.sv
// tube_scan_shifter: scans six segment codes onto a 74HC595 chain as {seg, one-hot select} frames.
// Optional TUBE_DIMMING_EN adds a bright port and per-slot PWM dimming on oe.
module tube_scan_shifter #(
  parameter int CLK_DIV     = 2,
  parameter int SCAN_CYCLES = 50000,
  parameter int PWM_STEPS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] data_in,
`ifdef TUBE_DIMMING_EN
  input  logic [3:0]  bright,
`endif
  output logic        shcp,
  output logic        stcp,
  output logic        ds,
  output logic        oe
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(SCAN_CYCLES) > 17 ? $clog2(SCAN_CYCLES) : 17;
  if (CLK_DIV < 1 || SCAN_CYCLES < 33 * CLK_DIV + 2 || PWM_STEPS < 1) begin : g_bad_params
    $error("tube_scan_shifter: parameter combination cannot fit a frame in one slot");
  end
  typedef enum logic [2:0] {LOAD, SHIFT_LO, SHIFT_HI, LATCH, HOLD} state_t;
  state_t state, nxt;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] slot_cnt;
  logic [3:0]    bit_idx;
  logic [2:0]    digit;
  logic [15:0]   frame, load_word;
  logic          div_end, slot_end, latch_end, shcp_d, stcp_d, ds_d, oe_d;
  assign div_end   = div_cnt == DW'(CLK_DIV - 1);
  assign slot_end  = slot_cnt == SW'(SCAN_CYCLES - 1);
  assign latch_end = state == LATCH && div_end;
  assign load_word = {data_in[8*digit +: 8], 8'b1 << digit};
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= LOAD;
      div_cnt  <= '0;
      slot_cnt <= '0;
      bit_idx  <= '0;
      digit    <= '0;
      frame    <= '0;
      shcp     <= 1'b0;
      stcp     <= 1'b0;
      ds       <= 1'b0;
      oe       <= 1'b1;
    end else begin
      state    <= nxt;
      div_cnt  <= (state != nxt || state == HOLD) ? '0 : div_cnt + 1'b1;
      slot_cnt <= (state == HOLD && slot_end) ? '0 : slot_cnt + 1'b1;
      bit_idx  <= state == LOAD ? 4'd15 : (state == SHIFT_HI && div_end) ? bit_idx - 4'd1 : bit_idx;
      digit    <= (state == HOLD && slot_end) ? (digit == 3'd5 ? 3'd0 : digit + 3'd1) : digit;
      frame    <= state == LOAD ? load_word : frame;
      shcp     <= shcp_d;
      stcp     <= stcp_d;
      ds       <= ds_d;
      oe       <= oe_d;
    end
  always_comb begin
    nxt = LOAD;
    case (state)
      LOAD:     nxt = SHIFT_LO;
      SHIFT_LO: nxt = div_end ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: nxt = div_end ? (bit_idx == 4'd0 ? LATCH : SHIFT_LO) : SHIFT_HI;
      LATCH:    nxt = div_end ? HOLD : LATCH;
      HOLD:     nxt = slot_end ? LOAD : HOLD;
      default:  nxt = LOAD;
    endcase
  end
`ifdef TUBE_DIMMING_EN
  localparam int PHASE_LEN = SCAN_CYCLES / PWM_STEPS;
  localparam int PW = $clog2(PWM_STEPS + 1);
  logic          lit;
  logic [3:0]    bright_q;
  logic [SW-1:0] ph_cnt;
  logic [PW-1:0] ph_idx;
  // Phase index saturates at PWM_STEPS so the slot remainder stays dark.
  always_ff @(posedge clk)
    if (!rst_n) begin
      lit      <= 1'b0;
      bright_q <= '0;
      ph_cnt   <= '0;
      ph_idx   <= '0;
    end else begin
      lit      <= lit | latch_end;
      bright_q <= state == LOAD ? bright : bright_q;
      ph_cnt   <= (state == LOAD || ph_cnt == SW'(PHASE_LEN - 1)) ? '0 : ph_cnt + 1'b1;
      ph_idx   <= state == LOAD ? '0 :
                  (ph_cnt == SW'(PHASE_LEN - 1) && ph_idx != PW'(PWM_STEPS)) ? ph_idx + 1'b1 : ph_idx;
    end
`endif
  // Outputs are registered from the next state so shcp/stcp are glitch-free and aligned with it.
  always_comb begin
    shcp_d = nxt == SHIFT_HI;
    stcp_d = nxt == LATCH;
    ds_d   = state == LOAD ? load_word[15] :
             (state == SHIFT_HI && div_end && bit_idx != 4'd0) ? frame[bit_idx - 4'd1] : ds;
`ifdef TUBE_DIMMING_EN
    oe_d   = !((lit || latch_end) && 32'(ph_idx) < 32'(bright_q));
`else
    oe_d   = latch_end ? 1'b0 : oe;
`endif
  end
endmodule

// File: tb/tb_tube_scan_shifter.sv
// tb_tube_scan_shifter: randomized frame checks against a slot-level model of the tube scanner.
module tb_tube_scan_shifter;
  localparam int SCAN = 100;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] data_in = '0;
  logic        shcp, stcp, ds, oe;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];

  tube_scan_shifter #(.CLK_DIV(2), .SCAN_CYCLES(SCAN), .PWM_STEPS(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe)
  );

  always #5 clk = ~clk;

  // Model: every slot starts SCAN clocks after the previous one and snapshots the current digit's byte.
  always @(posedge clk)
    if (!rst_n) begin
      cyc = 0;
      exp_q.delete();
    end else begin : model
      int d;
      d = (cyc / SCAN) % 6;
      if (cyc % SCAN == 0) exp_q.push_back({data_in[8*d +: 8], 8'(1 << d)});
      cyc++;
    end

  task automatic grab(output logic [15:0] w, output int nrise, output int stw, output bit ds_ok,
                      output bit wid_ok, output bit oe_pre, output bit oe_post, output int t_lat,
                      output bit tmo);
    logic ps, pl, pd;
    int hi, lo;
    ps = shcp; pl = stcp; pd = ds; hi = 0; lo = 0;
    w = '0; nrise = 0; stw = 0; ds_ok = 1; wid_ok = 1; oe_pre = 0; oe_post = 0; t_lat = 0; tmo = 1;
    for (int k = 0; k < 3 * SCAN; k++) begin
      @(negedge clk);
      if (shcp && !ps) begin
        if (ds !== pd) ds_ok = 0;
        if (nrise > 0 && lo != 2) wid_ok = 0;
        w = {w[14:0], ds};
        nrise++;
        hi = 0;
      end
      if (!shcp && ps) begin
        if (hi != 2) wid_ok = 0;
        lo = 0;
      end
      if (shcp) hi++; else lo++;
      if (stcp && !pl) begin oe_pre = oe; t_lat = cyc; end
      if (stcp) stw++;
      if (!stcp && pl) begin oe_post = oe; tmo = 0; break; end
      ps = shcp; pl = stcp; pd = ds;
    end
  endtask

  task automatic test_reset();
    logic [15:0] w; int nr, sw, tl; bit dok, wok, op, oq, tmo;
    data_in = 48'({$urandom(), $urandom()});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({shcp, stcp, ds, oe} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_idle: {shcp,stcp,ds,oe}=%b expected 0001", {shcp, stcp, ds, oe});
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({shcp, stcp, ds, oe} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_midshift: {shcp,stcp,ds,oe}=%b expected 0001", {shcp, stcp, ds, oe});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({shcp, stcp, ds, oe} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_held: {shcp,stcp,ds,oe}=%b expected 0001", {shcp, stcp, ds, oe});
    end
    rst_n = 1'b1;
    grab(w, nr, sw, dok, wok, op, oq, tl, tmo);
    void'(exp_q.pop_front());
    n_checks++;
    if (tmo || w !== {data_in[7:0], 8'h01}) begin
      n_fail++; $display("FAIL reset_restart: frame=%h timeout=%0d expected %h", w, tmo, {data_in[7:0], 8'h01});
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] w; int nr, sw, tl; bit dok, wok, op, oq, tmo;
    data_in = {40'({$urandom(), $urandom()}), 8'hC0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    grab(w, nr, sw, dok, wok, op, oq, tl, tmo);
    void'(exp_q.pop_front());
    n_checks++;
    if (tmo || w !== 16'hC001) begin n_fail++; $display("FAIL single_word: got %h timeout=%0d expected c001", w, tmo); end
    n_checks++;
    if (nr !== 16) begin n_fail++; $display("FAIL single_rises: got %0d expected 16", nr); end
    n_checks++;
    if (sw !== 2) begin n_fail++; $display("FAIL stcp_width: got %0d expected 2", sw); end
    n_checks++;
    if (!dok) begin n_fail++; $display("FAIL ds_stable: ds changed across a shcp rise, expected stable"); end
    n_checks++;
    if (!wok) begin n_fail++; $display("FAIL shcp_width: a high/low phase was not 2 clks, expected 2"); end
    n_checks++;
    if (op !== 1'b1) begin n_fail++; $display("FAIL oe_before_latch: got %b expected 1", op); end
    n_checks++;
    if (oq !== 1'b0) begin n_fail++; $display("FAIL oe_after_latch: got %b expected 0", oq); end
  endtask

  task automatic test_scan();
    logic [15:0] w, e; int nr, sw, tl, prev; bit dok, wok, op, oq, tmo;
    data_in = 48'({$urandom(), $urandom()});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      grab(w, nr, sw, dok, wok, op, oq, tl, tmo);
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      n_checks++;
      if (tmo || w !== e) begin n_fail++; $display("FAIL scan_frame%0d: got %h timeout=%0d expected %h", i, w, tmo, e); end
      n_checks++;
      if (w[7:0] !== 8'(1 << (i % 6))) begin
        n_fail++; $display("FAIL scan_sel%0d: got %h expected %h", i, w[7:0], 8'(1 << (i % 6)));
      end
      if (i > 0) begin
        n_checks++;
        if (tl - prev !== SCAN) begin n_fail++; $display("FAIL slot_period%0d: got %0d expected %0d", i, tl - prev, SCAN); end
      end
      prev = tl;
    end
    n_checks++;
    if (oe !== 1'b0) begin n_fail++; $display("FAIL oe_steady: got %b expected 0", oe); end
  endtask

  task automatic test_tearing();
    logic [7:0] old_b, new_b;
    int visits;
    bit chg_tmo;
    old_b = data_in[23:16];
    new_b = old_b ^ 8'(1 + $urandom_range(0, 254));
    visits = 0;
    chg_tmo = 1;
    fork
      begin
        for (int k = 0; k < 12 * SCAN; k++) begin
          @(negedge clk);
          if (cyc > 0 && ((cyc - 1) / SCAN) % 6 == 2 && (cyc - 1) % SCAN == 20) begin
            data_in[23:16] = new_b;
            chg_tmo = 0;
            break;
          end
        end
      end
      begin
        logic [15:0] w, e; int nr, sw, tl; bit dok, wok, op, oq, tmo;
        for (int i = 0; i < 12; i++) begin
          grab(w, nr, sw, dok, wok, op, oq, tl, tmo);
          e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
          n_checks++;
          if (tmo || w !== e) begin n_fail++; $display("FAIL tear_frame%0d: got %h timeout=%0d expected %h", i, w, tmo, e); end
          if (e[7:0] === 8'h04) begin
            visits++;
            n_checks++;
            if (w[15:8] !== (visits == 1 ? old_b : new_b)) begin
              n_fail++; $display("FAIL tear_digit2_visit%0d: got %h expected %h", visits, w[15:8], visits == 1 ? old_b : new_b);
            end
          end
        end
      end
    join
    n_checks++;
    if (chg_tmo || visits < 2) begin
      n_fail++; $display("FAIL tear_coverage: change_timeout=%0d visits=%0d expected 0 and >=2", chg_tmo, visits);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_scan();
    test_tearing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
